sll_iter: RTL
=============

Name: sll_iter

Overview:
- Multi-cycle logical left shifter.
- Applies one power-of-two shift stage per clock, LSB stage first, under a start/ready handshake.
- Provides the left-going counterpart to the ALU's combinational arithmetic right shifter.
- Intended for area-constrained datapaths where a shift result may arrive several cycles after issue.

Parameters:
- DATA_WIDTH, 32, operand/result width in bits.
- SHAMT_WIDTH, 5, shift-amount width; stage count = SHAMT_WIDTH; requires DATA_WIDTH = 2**SHAMT_WIDTH.

Ports:
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- ctrl_start  input  1  request; sampled on rising edge, accepted only when not busy.
- data_operandA  input  DATA_WIDTH  value to shift; captured on accept.
- ctrl_shiftamt  input  SHAMT_WIDTH  unsigned shift amount; captured on accept.
- ctrl_busy  output  1  high while a shift is in progress (states BUSY).
- data_result  output  DATA_WIDTH  shifted value; valid when data_resultRDY high, held afterwards.
- data_resultRDY  output  1  single-cycle pulse marking result valid.

Behaviour:
- Reset (async, any time incl. mid-operation):
  - state=IDLE, stage counter=0, work reg=0, amount reg=0.
  - data_result=0, data_resultRDY=0, ctrl_busy=0.
  - An in-flight shift is discarded with no RDY pulse.
- States: IDLE, BUSY, DONE.
- IDLE or DONE, ctrl_start=1 at edge N:
  - work <= data_operandA, amt <= ctrl_shiftamt, count <= 0, state <= BUSY.
- IDLE/DONE with ctrl_start=0: stay; DONE returns to IDLE after one cycle.
- BUSY, edge with count=k:
  - work <= amt[k] ? (work << 2**k) : work, zeros shifted in at LSBs; bits shifted past MSB lost.
  - If k = SHAMT_WIDTH-1: state <= DONE, data_result <= new work, data_resultRDY <= 1.
  - Otherwise count <= k+1.
- Latency fixed at SHAMT_WIDTH+1 edges regardless of amount:
  - start at edge N -> data_resultRDY high for exactly the cycle after edge N+SHAMT_WIDTH (N+5 at default).
  - shamt=0 takes the same latency.
- data_resultRDY is registered; it is 0 in every cycle except the DONE cycle.
- data_result changes only at the DONE-entry edge and holds until the next completion or reset.
- ctrl_busy is high from edge N through the edge that enters DONE (SHAMT_WIDTH cycles).
  - It is low in DONE so back-to-back issue is allowed.
- ctrl_start while BUSY is ignored:
  - not queued, no effect on work/amt/count.
  - issuer must wait for ctrl_busy=0.
- ctrl_start in the DONE cycle is accepted:
  - RDY still pulses for the completed result.
  - next op's RDY follows SHAMT_WIDTH+1 edges later.
- Operand/amount inputs may change freely after the accept edge; only captured copies are used.
- Result equals data_operandA << ctrl_shiftamt truncated to DATA_WIDTH; shamt=31 leaves only bit0 moved to bit31.

Test Plan:
- Reset then idle 10 cycles -> data_result=0, data_resultRDY=0, ctrl_busy=0 throughout.
- A=0x0000_0001, shamt=31, start at edge N -> RDY pulse exactly one cycle after edge N+5, data_result=0x8000_0000; ctrl_busy high 5 cycles.
- A=0xDEAD_BEEF, shamt=0 -> result 0xDEAD_BEEF after same 6-edge latency; A=0xFFFF_FFFF, shamt=4 -> 0xFFFF_FFF0; A=0x1234_5678, shamt=13 -> 0x8ACF_0000.
- Start A=0x1, shamt=1; assert start again with A=0xF, shamt=8 two cycles later while busy -> second request ignored; only result 0x2 produced; no second RDY.
- Back-to-back: second start (A=0x3, shamt=2) issued in DONE cycle of first (A=0x1, shamt=3) -> RDY pulses with 0x8 then, 6 edges later, 0xC.
- Assert reset asynchronously (mid-cycle) at BUSY count=2 of A=0xFF, shamt=20 -> outputs clear immediately, no RDY pulse; fresh start after release yields correct 0x0FF0_0000.

Source files
------------

// File: rtl/sll_iter_if.sv
// Issue/result bundle for the iterative left shifter.
// The issuer owns start/operand/amount; the shifter owns busy/result/ready.
interface sll_iter_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
);
    logic                   ctrl_start;
    logic [DATA_WIDTH-1:0]  data_operandA;
    logic [SHAMT_WIDTH-1:0] ctrl_shiftamt;
    logic                   ctrl_busy;
    logic [DATA_WIDTH-1:0]  data_result;
    logic                   data_resultRDY;

    modport master (
        output ctrl_start, data_operandA, ctrl_shiftamt,
        input  ctrl_busy, data_result, data_resultRDY
    );

    modport slave (
        input  ctrl_start, data_operandA, ctrl_shiftamt,
        output ctrl_busy, data_result, data_resultRDY
    );
endinterface

// File: rtl/sll_iter.sv
// Multi-cycle logical left shifter: one power-of-two stage per clock, LSB stage first.
// Fixed latency of SHAMT_WIDTH+1 edges from accept to the result-ready pulse.
module sll_iter #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic       clock,
    input  logic       reset,
    sll_iter_if.slave  bus,
    output logic [1:0] dbg_state
);
    // Handshake: a request is accepted on any rising edge where ctrl_start=1 and
    // ctrl_busy=0 (IDLE or DONE); requests while busy are dropped, not queued.
    // data_resultRDY is a one-cycle pulse; data_result holds until the next completion.

    localparam int CNT_W = (SHAMT_WIDTH > 1) ? $clog2(SHAMT_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(SHAMT_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                 state_q,  state_d;
    logic [CNT_W-1:0]       count_q,  count_d;
    logic [DATA_WIDTH-1:0]  work_q,   work_d;
    logic [SHAMT_WIDTH-1:0] amt_q,    amt_d;
    logic [DATA_WIDTH-1:0]  result_q, result_d;
    logic                   rdy_q,    rdy_d;

    logic [DATA_WIDTH-1:0]  stage_dist;
    logic [DATA_WIDTH-1:0]  stage_work;

    always_comb begin
        stage_dist = DATA_WIDTH'(1) << count_q;
        stage_work = amt_q[count_q] ? (work_q << stage_dist) : work_q;
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        work_d   = work_q;
        amt_d    = amt_q;
        result_d = result_q;
        rdy_d    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.ctrl_start) begin
                    work_d  = bus.data_operandA;
                    amt_d   = bus.ctrl_shiftamt;
                    count_d = '0;
                    state_d = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                work_d = stage_work;
                if (count_q == LAST_STAGE) begin
                    state_d  = S_DONE;
                    result_d = stage_work;
                    rdy_d    = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            work_q   <= '0;
            amt_q    <= '0;
            result_q <= '0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            work_q   <= work_d;
            amt_q    <= amt_d;
            result_q <= result_d;
            rdy_q    <= rdy_d;
        end
    end

    assign bus.ctrl_busy      = (state_q == S_BUSY);
    assign bus.data_result    = result_q;
    assign bus.data_resultRDY = rdy_q;
    assign dbg_state          = state_q;
endmodule
